pmi_ram_arbiter: RTL and testbench

Two-port arbiter that shares one single-port pmi_ram_dq instance between two requesters (port 0: timing engine, port 1: LM32 bus bridge) in the timing controller SoC. It accepts one read or write beat per cycle with valid/ready, supports locked bursts capped by a counter, and returns read data in order with a per-port response strobe. The RAM itself stays outside this block; only its Address/Data/WE/ClockEn/Q pins connect here.

---
 rtl/pmi_ram_arb_pkg.sv | 22 ++
 rtl/pmi_ram_arbiter_if.sv | 38 +++
 rtl/pmi_ram_arb_tagpipe.sv | 35 +++
 rtl/pmi_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_pmi_ram_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pmi_ram_arb_pkg.sv
// pmi_ram_arb_pkg
//   Shared types for the two-port RAM arbiter. It holds:
//   - grant_state_e: the grant FSM states (OPEN, LOCK0, LOCK1)
//   - rd_tag_t: the read-return tag {valid, port}
//   - PORT0 / PORT1: the requester ids
package pmi_ram_arb_pkg;

  typedef enum logic [1:0] {
    OPEN  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } grant_state_e;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/pmi_ram_arbiter_if.sv
// pmi_ram_arbiter_if
//   Requester-side bus of the RAM arbiter. There are two beat-request channels
//   (valid/ready, we, lock, addr, wdata) and two read-response strobes. The
//   read data is shared.
//   modport master : requester side (timing engine / LM32 bridge)
//   modport slave  : arbiter side
interface pmi_ram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 18
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic              req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic              req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data
  );
endinterface

// File: rtl/pmi_ram_arb_tagpipe.sv
// pmi_ram_arb_tagpipe
//   DEPTH-stage shift register of read tags. It runs in step with the RAM read
//   latency, so the tail marks the cycle in which the RAM Q output carries the
//   data for that tag.
//   clk   : clock
//   srst  : synchronous clear (drops all in-flight tags)
//   tag_i : tag entering the pipe, one per cycle
//   tag_o : tag at the tail
module pmi_ram_arb_tagpipe
  import pmi_ram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    srst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t [DEPTH-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pmi_ram_arbiter.sv
// pmi_ram_arbiter
//   Shares one single-port pmi_ram_dq between two requesters. It accepts one
//   read or write beat per cycle. Locked bursts are capped at MAX_LOCK beats.
//   Read responses come back in acceptance order.
//   Clock, Reset : clock and synchronous active-high reset
//   bus          : requester channels (pmi_ram_arbiter_if.slave)
//   ram_Address, ram_Data, ram_WE, ram_ClockEn : registered RAM strobes
//   ram_Q        : RAM read data, forwarded as bus.rsp_data
//   Build option: define PMI_RAM_ARB_FIXED_PRI_EN to make port 0 win
//   whenever both ports are valid in OPEN. The default is round robin.
module pmi_ram_arbiter
  import pmi_ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 18,
  parameter int RD_LATENCY = 2,
  parameter int MAX_LOCK   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  pmi_ram_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] ram_Address,
  output logic [DATA_W-1:0] ram_Data,
  output logic              ram_WE,
  output logic              ram_ClockEn,
  input  logic [DATA_W-1:0] ram_Q
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  grant_state_e      state_q;
  logic              last_served_q;
  logic [CNT_W-1:0]  lock_cnt_q;
  rd_tag_t           tag_q;
  rd_tag_t           tail_tag;

  logic              ready0, ready1;
  logic              acc, acc_port, acc_we, acc_lock;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  // Ready depends only on state, last_served and this cycle's valids. At most
  // one port gets ready, so at most one beat is accepted per cycle.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!Reset) begin
      case (state_q)
        OPEN: begin
          if (bus.req0_valid && bus.req1_valid) begin
`ifdef PMI_RAM_ARB_FIXED_PRI_EN
            ready0 = 1'b1;
`else
            ready0 = (last_served_q == PORT1);
            ready1 = (last_served_q == PORT0);
`endif
          end else begin
            ready0 = bus.req0_valid;
            ready1 = bus.req1_valid;
          end
        end
        LOCK0:   ready0 = bus.req0_valid;
        LOCK1:   ready1 = bus.req1_valid;
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  always_comb begin
    acc       = ready0 | ready1;
    acc_port  = ready1 ? PORT1 : PORT0;
    acc_we    = ready1 ? bus.req1_we    : bus.req0_we;
    acc_lock  = ready1 ? bus.req1_lock  : bus.req0_lock;
    acc_addr  = ready1 ? bus.req1_addr  : bus.req0_addr;
    acc_wdata = ready1 ? bus.req1_wdata : bus.req0_wdata;
  end

  // This block holds the grant FSM and the registered RAM strobes. tag_q runs
  // alongside the RAM inputs, so a tag enters the pipe on the edge where the
  // RAM samples that read.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= OPEN;
      last_served_q <= PORT1;
      lock_cnt_q    <= '0;
      ram_Address   <= '0;
      ram_Data      <= '0;
      ram_WE        <= 1'b0;
      ram_ClockEn   <= 1'b0;
      tag_q         <= '0;
    end else begin
      ram_ClockEn <= acc;
      ram_WE      <= acc & acc_we;
      tag_q.valid <= acc & ~acc_we;
      tag_q.port  <= acc_port;
      if (acc) begin
        ram_Address   <= acc_addr;
        ram_Data      <= acc_wdata;
        last_served_q <= acc_port;
        case (state_q)
          OPEN: begin
            if (acc_lock) begin
              state_q    <= (acc_port == PORT1) ? LOCK1 : LOCK0;
              lock_cnt_q <= CNT_W'(1);
            end
          end
          LOCK0, LOCK1: begin
            // This beat brings the count to MAX_LOCK, or it drops lock.
            if (!acc_lock || lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
              state_q    <= OPEN;
              lock_cnt_q <= '0;
            end else begin
              lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= OPEN;
        endcase
      end
    end
  end

  pmi_ram_arb_tagpipe #(
    .DEPTH (RD_LATENCY)
  ) u_tagpipe (
    .clk   (Clock),
    .srst  (Reset),
    .tag_i (tag_q),
    .tag_o (tail_tag)
  );

  assign bus.rsp0_valid = tail_tag.valid && (tail_tag.port == PORT0);
  assign bus.rsp1_valid = tail_tag.valid && (tail_tag.port == PORT1);
  assign bus.rsp_data   = ram_Q;

endmodule

// File: tb/tb_pmi_ram_arbiter.sv
// Bench for pmi_ram_arbiter. It contains a behavioural pmi_ram_dq ("reg" mode)
// and a transaction-level reference model. The model tracks the lock owner,
// the burst length, the last served port, a shadow memory and a queue of
// expected responses.
module tb_pmi_ram_arbiter;
  import pmi_ram_arb_pkg::*;

  localparam int AW   = 9;
  localparam int DW   = 18;
  localparam int RDL  = 2;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmi_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;
  logic          ram_we, ram_ce;

  pmi_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RDL), .MAX_LOCK(MAXL)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .bus         (bus),
    .ram_Address (ram_addr),
    .ram_Data    (ram_data),
    .ram_WE      (ram_we),
    .ram_ClockEn (ram_ce),
    .ram_Q       (ram_q)
  );

  // Behavioural single-port RAM. The read is sampled on an enabled edge, and
  // the output register adds one more cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q1, q2;
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        q1 <= mem[ram_addr];
    end
    q2 <= q1;
  end
  assign ram_q = (RDL == 1) ? q1 : q2;

  // ---------------- reference model ----------------
  typedef struct {
    int            port;
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          expq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            owner;      // -1 when no lock is held
  int            burst;
  int            last;
  int            cyc;
  int            checks;
  int            errors;

  bit            v  [2];
  bit            we [2];
  bit            lk [2];
  logic [AW-1:0] ad [2];
  logic [DW-1:0] wd [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit vv, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    v[p] = vv; we[p] = w; lk[p] = l; ad[p] = a; wd[p] = d;
    if (p == 0) begin
      bus.req0_valid = vv; bus.req0_we = w; bus.req0_lock = l;
      bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = vv; bus.req1_we = w; bus.req1_lock = l;
      bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    if (owner >= 0) return v[owner] ? owner : -1;
    if (v[0] && v[1]) begin
`ifdef PMI_RAM_ARB_FIXED_PRI_EN
      return 0;
`else
      return (last == 1) ? 0 : 1;
`endif
    end
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // One clock cycle. The caller sets the inputs just after a negedge. This
  // task checks ready, advances the model, crosses the edge, and then checks
  // the RAM strobes and the responses at the next negedge.
  task automatic step();
    int g;
    bit rst_e;
    bit e0, e1;
    logic [DW-1:0] ed;
    #1;
    g = model_grant();
    check_eq("req0_ready", bus.req0_ready, (g == 0));
    check_eq("req1_ready", bus.req1_ready, (g == 1));
    rst_e = rst;
    if (g >= 0) begin
      $display("cyc %0d accept port%0d %s addr=%h wdata=%h lock=%0d",
               cyc + 1, g, we[g] ? "WR" : "RD", ad[g], wd[g], lk[g]);
      if (we[g]) shadow[ad[g]] = wd[g];
      else expq.push_back('{port: g, due: cyc + 1 + RDL, data: shadow[ad[g]]});
      last = g;
      if (owner < 0) begin
        if (lk[g]) begin owner = g; burst = 1; end
      end else begin
        burst++;
        if (!lk[g] || burst == MAXL) owner = -1;
      end
    end
    @(posedge clk);
    cyc++;
    if (rst_e) begin
      owner = -1; burst = 0; last = 1;
      expq.delete();
    end
    @(negedge clk);
    check_eq("ram_ClockEn", ram_ce, (g >= 0));
    if (g >= 0) begin
      check_eq("ram_WE", ram_we, we[g]);
      check_eq("ram_Address", ram_addr, ad[g]);
    end
    e0 = 0; e1 = 0; ed = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e0 = (expq[0].port == 0);
      e1 = (expq[0].port == 1);
      ed = expq[0].data;
      void'(expq.pop_front());
    end
    check_eq("rsp0_valid", bus.rsp0_valid, e0);
    check_eq("rsp1_valid", bus.rsp1_valid, e1);
    if (e0 || e1) check_eq("rsp_data", bus.rsp_data, ed);
  endtask

  task automatic idle(input int n);
    set_req(0, 0, 0, 0, '0, '0);
    set_req(1, 0, 0, 0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    owner = -1; burst = 0; last = 1;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = DW'($urandom);
      shadow[i] = mem[i];
    end
    mem[5] = 18'h2AAAA; shadow[5] = 18'h2AAAA;
    q1 = '0; q2 = '0;

    // Reset: ready must stay low even with both ports valid.
    rst = 1'b1;
    set_req(0, 1, 0, 0, 9'h001, '0);
    set_req(1, 1, 0, 0, 9'h002, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_ready0", bus.req0_ready, 1'b0);
    check_eq("rst_ready1", bus.req1_ready, 1'b0);
    check_eq("rst_rsp0", bus.rsp0_valid, 1'b0);
    check_eq("rst_rsp1", bus.rsp1_valid, 1'b0);
    check_eq("rst_ce", ram_ce, 1'b0);
    check_eq("rst_we", ram_we, 1'b0);
    check_eq("rst_addr", ram_addr, '0);
    check_eq("rst_data", ram_data, '0);
    rst = 1'b0;
    idle(1);

    // Single read from port 0 of preloaded addr 0x005.
    set_req(0, 1, 0, 0, 9'h005, '0);
    step();
    idle(4);

    // Both ports valid, unlocked reads: grants alternate.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0, 0, AW'($urandom), '0);
      set_req(1, 1, 0, 0, AW'($urandom), '0);
      step();
    end
    idle(4);

    // Port 1 locked write burst (4 locked and 1 unlocked) while port 0 waits.
    set_req(0, 1, 0, 0, 9'h020, '0);
    for (int i = 0; i < 8; i++) begin
      set_req(1, 1, 1, (i < 4), AW'(9'h40 + i), DW'($urandom));
      step();
    end
    idle(4);

    // Port 0 holds lock continuously: the burst is cut at MAX_LOCK.
    set_req(1, 1, 0, 0, 9'h033, '0);
    for (int i = 0; i < MAXL + 4; i++) begin
      set_req(0, 1, 0, 1, AW'($urandom), '0);
      step();
    end
    idle(4);

    // Back-to-back write then read of the same address.
    set_req(0, 1, 1, 0, 9'h010, 18'h01234);
    step();
    set_req(0, 1, 0, 0, 9'h010, '0);
    step();
    idle(5);

    // Reset one cycle after a read is accepted: no response may appear.
    set_req(0, 1, 0, 0, 9'h005, '0);
    step();
    rst = 1'b1;
    step();
    check_eq("rst2_we", ram_we, 1'b0);
    check_eq("rst2_addr", ram_addr, '0);
    check_eq("rst2_data", ram_data, '0);
    rst = 1'b0;
    idle(5);

    // Randomized traffic, with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        set_req(p, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), DW'($urandom));
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle(6);
    check_eq("queue_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
